// File: rtl/out_fm_fifo_to_wmst_tile.sv
// Output-feature-map store back end: drains the store FIFO, packs words into
// XDW-wide beats and issues Avalon write-master bursts of at most BLEN words.
module out_fm_fifo_to_wmst_tile #(
  parameter int AW   = 12,
  parameter int DW   = 32,
  parameter int XAW  = 32,
  parameter int XDW  = 128,
  parameter int CW   = 16,
  parameter int WCNT = XDW / DW,
  parameter int BLEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_trans_start,
  input  logic [XAW-1:0]   param_waddr,
  input  logic [AW-1:0]    param_iolen,
  output logic             store_trans_done,
  output logic             store_fifo_pop,
  input  logic [DW-1:0]    store_fifo_data,
  input  logic             store_fifo_empty,
  output logic             wmst_fixed_location,
  output logic [XAW-1:0]   wmst_write_base,
  output logic [CW-1:0]    wmst_write_length,
  output logic             wmst_go,
  input  logic             wmst_done,
  output logic             wmst_user_write_buffer,
  output logic [XDW-1:0]   wmst_user_buffer_data,
  input  logic             wmst_user_buffer_full
);

  localparam int LW = $clog2(WCNT + 1);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_FILL, S_WAIT, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [XAW-1:0]  wbase_reg;
  logic [CW-1:0]   wlen_reg;
  logic [AW-1:0]   rem_reg;
  logic [AW-1:0]   bw_reg;
  logic [AW-1:0]   burst_left_reg;
  logic [LW-1:0]   pop_cnt_reg;
  logic [LW-1:0]   lane_cnt_reg;
  logic            pend_reg;
  logic [XDW-1:0]  beat_reg;
  logic            done_low_reg;
  logic            done_reg;

  logic [AW-1:0]   bw_calc;
  logic [AW-1:0]   rem_after;
  logic [LW-1:0]   beat_words;
  logic [LW-1:0]   lanes_now;
  logic            beat_ready;
  logic            pop;
  logic            push;
  logic [XDW-1:0]  lane_in;
  logic [XDW-1:0]  beat_cur;

  function automatic logic [AW-1:0] min_blen(input logic [AW-1:0] x);
    return (x < AW'(BLEN)) ? x : AW'(BLEN);
  endfunction

  function automatic logic [CW-1:0] len_bytes(input logic [AW-1:0] words);
    return CW'(words) << 2;
  endfunction

  assign bw_calc    = min_blen(rem_reg);
  assign rem_after  = rem_reg - bw_reg;
  assign beat_words = (burst_left_reg < AW'(WCNT)) ? burst_left_reg[LW-1:0] : LW'(WCNT);
  // The word popped last cycle counts toward the beat now, so a beat can be
  // pushed in the same cycle its final word arrives from the FIFO.
  assign lanes_now  = lane_cnt_reg + LW'(pend_reg);
  assign beat_ready = (state_reg == S_FILL) && (lanes_now == beat_words);
  assign pop        = (state_reg == S_FILL) && !store_fifo_empty &&
                      (pop_cnt_reg < beat_words) && !beat_ready;
  assign push       = beat_ready && !wmst_user_buffer_full;

  for (genvar gi = 0; gi < WCNT; gi++) begin : g_lane
    assign lane_in[gi*DW +: DW] = (pend_reg && lane_cnt_reg == LW'(gi)) ? store_fifo_data : '0;
  end

  assign beat_cur               = beat_reg | lane_in;
  assign store_fifo_pop         = pop;
  assign wmst_user_write_buffer = push;
  assign wmst_user_buffer_data  = beat_cur;
  assign wmst_write_base        = wbase_reg;
  assign wmst_write_length      = wlen_reg;
  assign wmst_fixed_location    = 1'b0;
  assign store_trans_done       = done_reg;

  always_comb begin
    state_next = state_reg;
    wmst_go    = 1'b0;
    case (state_reg)
      S_IDLE: if (store_trans_start) state_next = (param_iolen == '0) ? S_DONE : S_GO;
      S_GO: begin
        wmst_go    = 1'b1;
        state_next = S_FILL;
      end
      S_FILL: if (push && burst_left_reg == AW'(beat_words)) state_next = S_WAIT;
      S_WAIT: if (done_low_reg && wmst_done) state_next = (rem_after != '0) ? S_GO : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wbase_reg      <= '0;
      wlen_reg       <= '0;
      rem_reg        <= '0;
      bw_reg         <= '0;
      burst_left_reg <= '0;
      pop_cnt_reg    <= '0;
      lane_cnt_reg   <= '0;
      pend_reg       <= 1'b0;
      beat_reg       <= '0;
      done_low_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == S_DONE);
      pend_reg  <= pop;
      case (state_reg)
        S_IDLE: begin
          if (store_trans_start) begin
            wbase_reg <= param_waddr;
            rem_reg   <= param_iolen;
            if (param_iolen != '0) wlen_reg <= len_bytes(min_blen(param_iolen));
          end
        end
        S_GO: begin
          bw_reg         <= bw_calc;
          burst_left_reg <= bw_calc;
          done_low_reg   <= 1'b0;
          pop_cnt_reg    <= '0;
          lane_cnt_reg   <= '0;
          beat_reg       <= '0;
        end
        S_FILL: begin
          if (push) begin
            beat_reg       <= '0;
            pop_cnt_reg    <= '0;
            lane_cnt_reg   <= '0;
            burst_left_reg <= burst_left_reg - AW'(beat_words);
          end else begin
            if (pop) pop_cnt_reg <= pop_cnt_reg + 1'b1;
            // Fold the arriving word in so it survives a full-buffer stall.
            if (pend_reg) begin
              beat_reg     <= beat_cur;
              lane_cnt_reg <= lane_cnt_reg + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!wmst_done) done_low_reg <= 1'b1;
          if (done_low_reg && wmst_done) begin
            rem_reg   <= rem_after;
            wbase_reg <= wbase_reg + (XAW'(bw_reg) << 2);
            if (rem_after != '0) wlen_reg <= len_bytes(min_blen(rem_after));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_out_fm_fifo_to_wmst_tile.sv
// Bench for out_fm_fifo_to_wmst_tile: FIFO and write-master models, a burst/beat
// reference built from the transaction rules, table vectors and corner sequences.
module tb_out_fm_fifo_to_wmst_tile;

  localparam int WCNT = 4;
  localparam int BLEN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          store_trans_start = 1'b0;
  logic [31:0]   param_waddr = '0;
  logic [11:0]   param_iolen = '0;
  logic          store_trans_done;
  logic          store_fifo_pop;
  logic [31:0]   store_fifo_data = '0;
  logic          store_fifo_empty = 1'b1;
  logic          wmst_fixed_location;
  logic [31:0]   wmst_write_base;
  logic [15:0]   wmst_write_length;
  logic          wmst_go;
  logic          wmst_done = 1'b1;
  logic          wmst_user_write_buffer;
  logic [127:0]  wmst_user_buffer_data;
  logic          wmst_user_buffer_full = 1'b0;

  out_fm_fifo_to_wmst_tile dut (
    .clk(clk), .rst(rst),
    .store_trans_start(store_trans_start), .param_waddr(param_waddr), .param_iolen(param_iolen),
    .store_trans_done(store_trans_done),
    .store_fifo_pop(store_fifo_pop), .store_fifo_data(store_fifo_data), .store_fifo_empty(store_fifo_empty),
    .wmst_fixed_location(wmst_fixed_location), .wmst_write_base(wmst_write_base),
    .wmst_write_length(wmst_write_length), .wmst_go(wmst_go), .wmst_done(wmst_done),
    .wmst_user_write_buffer(wmst_user_write_buffer), .wmst_user_buffer_data(wmst_user_buffer_data),
    .wmst_user_buffer_full(wmst_user_buffer_full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // environment state
  logic [31:0]  fifo_q[$];
  logic [31:0]  go_base_q[$];
  logic [15:0]  go_len_q[$];
  logic [127:0] beat_q[$];
  int  cyc = 0;
  int  pops, go_cnt, done_cnt, viol;
  int  start_cyc, go_cyc, first_pop_cyc, first_wr_cyc, done_cyc, rise_cyc;
  int  empty_pct = 0, full_pct = 0;
  bit  empty_force = 0, full_force = 0;
  bit  pop_prev = 0, mbusy = 0;
  int  mbeats_left = 0, mdelay = 0;

  task automatic clear_rec();
    go_base_q.delete(); go_len_q.delete(); beat_q.delete();
    pops = 0; go_cnt = 0; done_cnt = 0; viol = 0;
    start_cyc = -1; go_cyc = -1; first_pop_cyc = -1; first_wr_cyc = -1; done_cyc = -1; rise_cyc = -1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // FIFO and write-master models: inputs driven at +1, outputs sampled at +2
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mbusy && mbeats_left == 0) begin
      if (mdelay == 0) begin mbusy = 0; rise_cyc = cyc; end
      else mdelay--;
    end
    if (pop_prev && fifo_q.size() > 0) store_fifo_data = fifo_q.pop_front();
    else store_fifo_data = $urandom;
    store_fifo_empty = (fifo_q.size() == 0) || empty_force || ($urandom_range(99) < empty_pct);
    wmst_user_buffer_full = full_force || ($urandom_range(99) < full_pct);
    wmst_done = !mbusy;
    #1;
    if (rst) begin
      pop_prev = 0; mbusy = 0; mbeats_left = 0;
    end else begin
      pop_prev = store_fifo_pop;
      if (store_trans_start) start_cyc = cyc;
      if (store_fifo_pop) begin
        pops++;
        if (store_fifo_empty) viol++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (wmst_go) begin
        if (mbusy) viol++;
        go_cnt++;
        if (go_cyc < 0) go_cyc = cyc;
        go_base_q.push_back(wmst_write_base);
        go_len_q.push_back(wmst_write_length);
        mbusy = 1;
        mbeats_left = (int'(wmst_write_length) / 4 + WCNT - 1) / WCNT;
        mdelay = 3;
      end
      if (wmst_user_write_buffer) begin
        if (wmst_user_buffer_full) viol++;
        else begin
          beat_q.push_back(wmst_user_buffer_data);
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          if (mbeats_left > 0) mbeats_left--;
        end
      end
      if (store_trans_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic start_pulse(input logic [31:0] waddr, input int iolen);
    @(posedge clk); #1;
    store_trans_start = 1; param_waddr = waddr; param_iolen = 12'(iolen);
    @(posedge clk); #1;
    store_trans_start = 0;
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (done_cnt == 0 && c < limit) begin @(posedge clk); c++; end
    repeat (4) @(posedge clk);
    check("done_pulse_count", done_cnt, 1);
  endtask

  task automatic run_trans(input logic [31:0] waddr, input int iolen, input int epct,
                           input int fpct, input int exp_bursts, input string label);
    logic [31:0]  w[$];
    logic [31:0]  exp_base[$];
    logic [15:0]  exp_len[$];
    logic [127:0] exp_beat[$];
    logic [31:0]  addr;
    logic [127:0] beat;
    int left, b, idx, nb, nbt;
    clear_rec();
    for (int i = 0; i < iolen; i++) w.push_back($urandom);
    fifo_q = w;
    addr = waddr; left = iolen; idx = 0;
    while (left > 0) begin
      b = (left < BLEN) ? left : BLEN;
      exp_base.push_back(addr);
      exp_len.push_back(16'(b * 4));
      for (int i = 0; i < b; i += WCNT) begin
        beat = '0;
        for (int k = 0; k < WCNT && i + k < b; k++) begin beat[k*32 +: 32] = w[idx]; idx++; end
        exp_beat.push_back(beat);
      end
      addr = addr + 32'(b * 4);
      left -= b;
    end
    empty_pct = epct; full_pct = fpct;
    start_pulse(waddr, iolen);
    wait_done(3000);
    empty_pct = 0; full_pct = 0;
    nb = go_base_q.size(); nbt = beat_q.size();
    check({label, "_bursts_table"}, nb, exp_bursts);
    check({label, "_bursts_model"}, nb, exp_base.size());
    for (int i = 0; i < nb && i < exp_base.size(); i++) begin
      check({label, "_base"}, go_base_q[i], exp_base[i]);
      check({label, "_len"}, go_len_q[i], exp_len[i]);
    end
    check({label, "_beats"}, nbt, exp_beat.size());
    for (int i = 0; i < nbt && i < exp_beat.size(); i++) check({label, "_beat_data"}, beat_q[i], exp_beat[i]);
    check({label, "_pops"}, pops, iolen);
    check({label, "_protocol"}, viol, 0);
    $display("[TB] trans %s waddr=%h iolen=%0d bursts=%0d beats=%0d pops=%0d", label, waddr, iolen, nb, nbt, pops);
  endtask

  typedef struct {
    logic [31:0] waddr;
    int          iolen;
    int          epct;
    int          fpct;
    int          exp_bursts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_1000,  8,  0,  0, 1};
    vecs[1] = '{32'h0000_1000, 19,  0,  0, 3};
    vecs[2] = '{32'h0000_2000,  1,  0,  0, 1};
    vecs[3] = '{32'h0000_0FFC, 16, 30,  0, 2};
    vecs[4] = '{32'h0000_3000, 13,  0, 40, 2};
    vecs[5] = '{32'hFFFF_FFF0, 20, 25, 25, 3};

    clear_rec();
    repeat (4) @(posedge clk);
    #1 rst = 0;
    #1;
    check("rst_pop", store_fifo_pop, 0);
    check("rst_go", wmst_go, 0);
    check("rst_write", wmst_user_write_buffer, 0);
    check("rst_data", wmst_user_buffer_data, 0);
    check("rst_base", wmst_write_base, 0);
    check("rst_len", wmst_write_length, 0);
    check("rst_done", store_trans_done, 0);
    check("rst_fixed", wmst_fixed_location, 0);

    // single full burst with known data and latency
    clear_rec();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
    start_pulse(32'h1000, 8);
    wait_done(500);
    check("full_go_cnt", go_cnt, 1);
    if (go_base_q.size() > 0) begin
      check("full_base", go_base_q[0], 32'h1000);
      check("full_len", go_len_q[0], 16'd32);
    end
    check("full_beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      check("full_beat0", beat_q[0], {32'd4, 32'd3, 32'd2, 32'd1});
      check("full_beat1", beat_q[1], {32'd8, 32'd7, 32'd6, 32'd5});
    end
    check("lat_go", go_cyc - start_cyc, 1);
    check("lat_pop", first_pop_cyc - start_cyc, 2);
    check("lat_write", first_wr_cyc - start_cyc, 2 + WCNT);
    check("done_after_rise", done_cyc > rise_cyc && rise_cyc > 0, 1);
    $display("[TB] trans single_full go=%0d beats=%0d done_cyc=%0d", go_cnt, beat_q.size(), done_cyc - start_cyc);

    // zero-length transaction
    clear_rec();
    start_pulse(32'h4000, 0);
    wait_done(50);
    check("zero_done_lat", done_cyc - start_cyc, 2);
    check("zero_no_go", go_cnt, 0);
    $display("[TB] trans zero_len done_lat=%0d go=%0d", done_cyc - start_cyc, go_cnt);

    // FIFO underflow stall after word 3
    clear_rec();
    for (int i = 1; i <= 3; i++) fifo_q.push_back(32'(i));
    start_pulse(32'h1000, 8);
    repeat (20) @(posedge clk);
    check("uflow_no_write", beat_q.size(), 0);
    check("uflow_pops", pops, 3);
    for (int i = 4; i <= 8; i++) fifo_q.push_back(32'(i));
    wait_done(500);
    check("uflow_beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      check("uflow_beat0", beat_q[0], {32'd4, 32'd3, 32'd2, 32'd1});
      check("uflow_beat1", beat_q[1], {32'd8, 32'd7, 32'd6, 32'd5});
    end
    check("uflow_protocol", viol, 0);
    $display("[TB] trans underflow beats=%0d pops=%0d", beat_q.size(), pops);

    // backpressure with a beat ready
    clear_rec();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
    full_force = 1;
    start_pulse(32'h1000, 8);
    repeat (12) @(posedge clk);
    check("bp_no_write", beat_q.size(), 0);
    check("bp_pops_stop", pops, WCNT);
    full_force = 0;
    wait_done(500);
    check("bp_beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      check("bp_beat0", beat_q[0], {32'd4, 32'd3, 32'd2, 32'd1});
      check("bp_beat1", beat_q[1], {32'd8, 32'd7, 32'd6, 32'd5});
    end
    check("bp_pops", pops, 8);
    check("bp_protocol", viol, 0);
    $display("[TB] trans backpressure beats=%0d pops=%0d", beat_q.size(), pops);

    // second start during FILL is ignored
    clear_rec();
    for (int i = 1; i <= 11; i++) fifo_q.push_back(32'(i));
    start_pulse(32'h1000, 8);
    repeat (2) @(posedge clk);
    start_pulse(32'h5000, 3);
    wait_done(500);
    repeat (10) @(posedge clk);
    check("restart_go_cnt", go_cnt, 1);
    if (go_base_q.size() > 0) check("restart_base", go_base_q[0], 32'h1000);
    check("restart_beats", beat_q.size(), 2);
    check("restart_pops", pops, 8);
    check("restart_done_cnt", done_cnt, 1);
    $display("[TB] trans second_start go=%0d pops=%0d", go_cnt, pops);

    // reset mid-burst
    clear_rec();
    fifo_q.delete();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
    start_pulse(32'h1000, 8);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    #1;
    check("mrst_pop", store_fifo_pop, 0);
    check("mrst_go", wmst_go, 0);
    check("mrst_write", wmst_user_write_buffer, 0);
    check("mrst_data", wmst_user_buffer_data, 0);
    check("mrst_base", wmst_write_base, 0);
    check("mrst_len", wmst_write_length, 0);
    repeat (20) @(posedge clk);
    check("mrst_no_done", done_cnt, 0);
    $display("[TB] trans reset_mid_burst done=%0d", done_cnt);
    fifo_q.delete();
    run_trans(32'h1000, 8, 0, 0, 1, "after_reset");

    // table vectors
    for (int v = 0; v < 6; v++)
      run_trans(vecs[v].waddr, vecs[v].iolen, vecs[v].epct, vecs[v].fpct, vecs[v].exp_bursts, $sformatf("vec%0d", v));

    // randomized transactions
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(40, 1);
      run_trans($urandom & 32'hFFFF_FFFC, len, $urandom_range(40, 0), $urandom_range(40, 0),
                (len + BLEN - 1) / BLEN, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_fm_fifo_to_wmst_tile.md
# out_fm_fifo_to_wmst_tile

Store-side back end of the convolution accelerator's output-feature-map path. It drains finished output words from the local store FIFO, packs them into XDW-wide beats and drives an Avalon write master in bursts of at most BLEN words. It moves one contiguous transaction per `store_trans_start`; each transaction is given as a byte base address and a word count by the out-FM store controller. It is the write-direction counterpart of the read-master-to-FIFO tile loader.

## Interface
Parameters:
- `AW`, 12: width of word counters and of the transaction length.
- `DW`, 32: FIFO word width.
- `XAW`, 32: write-master address width.
- `XDW`, 128: write-master data width.
- `CW`, 16: width of the write-length port.
- `WCNT`, XDW/DW: words per beat. Must be ≥2.
- `BLEN`, 8: maximum words per burst. Must be a multiple of WCNT.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `store_trans_start`, input, 1: one-cycle start pulse.
- `param_waddr`, input, XAW: byte base address, 4-byte aligned.
- `param_iolen`, input, AW: word count.
- `store_trans_done`, output, 1: one-cycle pulse when the transaction completes.
- `store_fifo_pop`, input/output: output, 1: pop request to the FIFO.
- `store_fifo_data`, input, DW: FIFO data, valid the cycle after a pop.
- `store_fifo_empty`, input, 1: FIFO empty flag.
- `wmst_fixed_location`, output, 1: constant 0.
- `wmst_write_base`, output, XAW: byte address of the current burst.
- `wmst_write_length`, output, CW: byte length of the current burst.
- `wmst_go`, output, 1: one-cycle burst start.
- `wmst_done`, input, 1: high while the master is idle.
- `wmst_user_write_buffer`, output, 1: push one beat.
- `wmst_user_buffer_data`, output, XDW: beat data.
- `wmst_user_buffer_full`, input, 1: master buffer full.

## Operation
- FSM states: IDLE, GO, FILL, WAIT, DONE.
- **IDLE:** On `store_trans_start`, latch `param_waddr` into the base register and `param_iolen` into `rem`.
  - If `param_iolen == 0`, go to DONE.
  - Otherwise go to GO.
  - `store_trans_start` is ignored in every other state.
- **GO:** Assert `wmst_go` for exactly this one cycle.
  - `bw = min(rem, BLEN)`.
  - `wmst_write_length = bw << 2`. This is held stable from GO until the next GO.
  - `wmst_write_base` is the current base.
  - Go to FILL and clear the `done_low` flag.
- **FILL:** Pack the burst's `bw` words into beats.
  - Beat word count: `beat_words = min(WCNT, words left in burst)`.
  - `pop_cnt` counts pops issued for the current beat, including any still in flight.
  - `store_fifo_pop = FILL && !store_fifo_empty && pop_cnt < beat_words && !beat_ready`.
  - Data arriving one cycle after a pop goes to lane `lane_cnt`, in bits [DW*lane+DW-1 : DW*lane]. Word 0 goes to lane 0.
  - Lanes above `beat_words` are zero.
  - When `lane_cnt == beat_words`, set `beat_ready`.
  - `wmst_user_write_buffer = beat_ready && !wmst_user_buffer_full`. On that cycle, clear the beat register, `pop_cnt` and `lane_cnt`.
  - After the last beat of the burst is pushed, go to WAIT.
- **WAIT:** Set `done_low` when `wmst_done == 0`.
  - When `done_low && wmst_done`: `base += bw<<2` and `rem -= bw`.
  - Then go to GO if `rem != 0`, else to DONE.
- **DONE:** Assert `store_trans_done` for one cycle, then return to IDLE.
- Arithmetic: all address arithmetic is unsigned modulo 2^XAW; wrap-around is not flagged. `rem` never underflows because `bw ≤ rem`.

## Timing
- Reset state: IDLE, with all counters, the beat register and every output equal to 0.
  - Reset mid-transaction aborts the transaction: no `store_trans_done` pulse, and FIFO data of a pop still in flight is discarded.
- Start latency: a start at cycle T gives `wmst_go` at T+1. The first pop is no earlier than T+2; its data is captured at T+3.
- With no stalls, the first beat's `wmst_user_write_buffer` is at T+2+WCNT.
- Beat throughput: one beat per WCNT+1 cycles. Only one beat is buffered internally.
- Stall rules:
  - `store_fifo_empty` stalls pops only; captured lanes are held.
  - `wmst_user_buffer_full` holds `beat_ready` and the data, and blocks new pops.
  - Both stalls may be asserted at once, and for any duration.
- Zero-length transaction: a start with `param_iolen == 0` at T gives `store_trans_done` at T+2, with no `wmst_go`.
- `store_trans_done` is asserted no earlier than 1 cycle after the final `wmst_done` rise.

## Test plan
- **Single full burst.** waddr=0x1000, iolen=8, FIFO holds 1..8 → one `wmst_go` with base 0x1000 and length 32. Beats are {4,3,2,1} then {8,7,6,5} (lane3..lane0). One done pulse after the `wmst_done` rise.
- **Multi-burst with partial tail.** iolen=19 → bases 0x1000/0x1020/0x1040 with lengths 32/32/12. Last beat is {0,19,18,17}. Exactly 19 pops.
- **FIFO underflow stall.** `store_fifo_empty` high for 20 cycles after word 3 → no pops and no write while empty; the beat order is unchanged afterwards.
- **Backpressure.** `wmst_user_buffer_full` high for 10 cycles with a beat ready → write low, pops stop at WCNT. The beat is pushed on the first not-full cycle and no word is lost or duplicated.
- **Degenerate and illegal starts.** iolen=0 → done at T+2 and no `wmst_go`. A second `store_trans_start` during FILL has no effect on `rem` or base.
- **Reset mid-burst.** `rst` asserted during FILL → all outputs 0 the next cycle. A following start with iolen=8 completes normally.
